line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
// - Single-clock controller for the line-buffer dual-port BRAM: write port 2048 x 8b, read port 512 x 32b.
// - Generates write/read enables, write-enable, both BRAM addresses and the 3-bit window-mux select.
// - Generates the read count, the pause back-pressure to the pixel source, and a completion flag.
// - Sits between the external pixel source, the BRAM and the 3x3 window mux.
// PARAMETERS
// - W_ADDR_W    11    write-port address width (byte addressed)
// - R_ADDR_W    9     read-port address width (32-bit word addressed)
// - LEAD_WORDS  8     words written before reading starts (write lead = 4*LEAD_WORDS bytes)
// - TOTAL_WORDS 512   words read per frame; bytes written per frame = 4*TOTAL_WORDS
// PORTS
// - clk          in   1   single clock, rising edge
// - reset        in   1   asynchronous, active-low reset
// - start        in   3   run request; any nonzero value = run, 0 = hold/stop
// - en_wr        out  1   BRAM port-A enable
// - wea          out  1   BRAM port-A write enable
// - W_BRAM_ADDR  out  11  BRAM port-A byte address
// - en_rd        out  1   BRAM port-B enable
// - R_BRAM_ADDR  out  9   BRAM port-B word address
// - sel          out  3   window-mux select
// - count        out  9   number of words issued for read, modulo 512
// - pause        out  1   stalls the pixel source (source holds its data while 1)
// - complete     out  1   frame finished, sticky
// BEHAVIOUR
// - All outputs are registered.
// - reset low (any time, including mid-frame): state=IDLE and every output = 0 immediately.
// - FSM states: IDLE, FILL, STREAM, DRAIN, HOLD, DONE.
// - IDLE: outputs 0. Edge with start!=0 -> FILL; en_wr=wea=1 and W_BRAM_ADDR=0 after that edge.
// - FILL: W_BRAM_ADDR +1 per cycle, en_rd=0.
//   - At the edge where W goes 4*LEAD_WORDS-1 -> 4*LEAD_WORDS: enter STREAM; en_rd=1, R_BRAM_ADDR=0, phase=0.
// - STREAM: per cycle, W +1 and 2-bit phase +1.
//   - When phase==3: R_BRAM_ADDR +1 and count +1 (both wrap at 512).
//   - sel +1 every cycle, wrapping 7->0.
// - Last byte: after W reaches 4*TOTAL_WORDS-1 has been written (W wraps to 0):
//   - en_wr=wea=0; enter DRAIN; reads continue at the same cadence.
// - DRAIN -> DONE: at the phase==3 edge where count becomes TOTAL_WORDS (mod 512 -> 0).
// - DONE: en_rd=en_wr=wea=0, complete=1. Addresses, sel, count and phase hold.
//   - start==0 -> IDLE; complete clears and counters zero.
// - HOLD: start==0 during FILL/STREAM/DRAIN -> HOLD.
//   - pause=1, en_wr=wea=en_rd=0; all counters frozen.
//   - start!=0 -> resume the saved state, pause=0 on the next edge.
// - Overrun guard: if (W - 4*R) mod 2048 >= 2044, then pause=1 and wea=0 for that cycle.
//   - W holds; reads continue.
// - Simultaneous start drop and last-read edge: DONE has priority.
// TESTING
// - reset low mid-STREAM -> all outputs 0 at once; release with start=1 -> W_BRAM_ADDR=0, en_wr=1 after 1st edge.
// - start=1 from reset -> W increments 0..31; R_BRAM_ADDR=0, en_rd=1 when W=32.
//   - R=1, count=1 after 4 more edges; sel counts 0..7,0.
// - Full frame -> 2048 write pulses, 512 read increments; complete=1, en_*=0; start=0 -> IDLE with complete=0.
// - start=0 for 5 cycles at W=100 -> pause=1, en_wr=en_rd=0, W/R/count frozen; start=1 -> resumes at W=100.
// - Forced W-4R=2044 -> pause=1, wea=0, W holds until R advances.
// - start=3'b100 behaves identically to start=3'b001.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Controller for the line-buffer dual-port BRAM (write port 2048 x 8b byte
// addressed, read port 512 x 32b word addressed). Streams one frame of bytes
// into port A from a pixel source, starts reading words from port B once a
// fixed lead of words has been written, drives the 3x3 window-mux select,
// applies back-pressure to the source and flags frame completion.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   start[2:0]   in   run request, any nonzero value = run, 0 = hold/stop
//   en_wr        out  BRAM port-A enable
//   wea          out  BRAM port-A write enable
//   W_BRAM_ADDR  out  BRAM port-A byte address
//   en_rd        out  BRAM port-B enable
//   R_BRAM_ADDR  out  BRAM port-B word address
//   sel[2:0]     out  window-mux select
//   count        out  words issued for read, modulo 512
//   pause        out  stalls the pixel source while 1
//   complete     out  frame finished (sticky until start drops)
// All outputs are registered.
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter int W_ADDR_W    = 11,
    parameter int R_ADDR_W    = 9,
    parameter int LEAD_WORDS  = 8,
    parameter int TOTAL_WORDS = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          start,
    output logic                en_wr,
    output logic                wea,
    output logic [W_ADDR_W-1:0] W_BRAM_ADDR,
    output logic                en_rd,
    output logic [R_ADDR_W-1:0] R_BRAM_ADDR,
    output logic [2:0]          sel,
    output logic [R_ADDR_W-1:0] count,
    output logic                pause,
    output logic                complete
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [W_ADDR_W-1:0] W_ZERO    = W_ADDR_W'(0);
    localparam logic [W_ADDR_W-1:0] W_ONE     = W_ADDR_W'(1);
    localparam logic [W_ADDR_W-1:0] LEAD_LAST = W_ADDR_W'(4 * LEAD_WORDS - 1);
    localparam logic [W_ADDR_W-1:0] W_LAST    = W_ADDR_W'(4 * TOTAL_WORDS - 1);
    // Write pointer may run at most one word (4 bytes) short of lapping the reader.
    localparam logic [W_ADDR_W-1:0] GUARD_LIM = W_ADDR_W'((2 ** W_ADDR_W) - 4);
    localparam logic [R_ADDR_W-1:0] R_ZERO    = R_ADDR_W'(0);
    localparam logic [R_ADDR_W-1:0] R_ONE     = R_ADDR_W'(1);
    localparam logic [R_ADDR_W-1:0] CNT_LAST  = R_ADDR_W'(TOTAL_WORDS - 1);

    // True when the byte write pointer is about to overrun unread words.
    function automatic logic overrun(input logic [W_ADDR_W-1:0] w,
                                     input logic [R_ADDR_W-1:0] r);
        logic [W_ADDR_W-1:0] diff;
        diff = w - W_ADDR_W'({r, 2'b00});
        return (diff >= GUARD_LIM);
    endfunction

    state_t                state_r;
    state_t                saved_r;
    logic [W_ADDR_W-1:0]   w_addr_r;
    logic [R_ADDR_W-1:0]   r_addr_r;
    logic [R_ADDR_W-1:0]   count_r;
    logic [1:0]            phase_r;
    logic [2:0]            sel_r;
    logic                  en_wr_r;
    logic                  wea_r;
    logic                  en_rd_r;
    logic                  pause_r;
    logic                  complete_r;

    logic                  run_s;
    logic                  guard_s;
    logic                  read_step_s;

    // Decode of the run request, overrun guard and word-boundary phase.
    always_comb begin
        run_s       = (start != 3'd0);
        guard_s     = overrun(w_addr_r, r_addr_r);
        read_step_s = (phase_r == 2'd3);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            saved_r    <= IDLE;
            w_addr_r   <= W_ZERO;
            r_addr_r   <= R_ZERO;
            count_r    <= R_ZERO;
            phase_r    <= 2'd0;
            sel_r      <= 3'd0;
            en_wr_r    <= 1'b0;
            wea_r      <= 1'b0;
            en_rd_r    <= 1'b0;
            pause_r    <= 1'b0;
            complete_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (run_s) begin
                        state_r  <= FILL;
                        en_wr_r  <= 1'b1;
                        wea_r    <= 1'b1;
                        w_addr_r <= W_ZERO;
                    end else begin
                        state_r  <= IDLE;
                    end
                end

                FILL: begin
                    if (!run_s) begin
                        state_r <= HOLD;
                        saved_r <= FILL;
                        en_wr_r <= 1'b0;
                        wea_r   <= 1'b0;
                        en_rd_r <= 1'b0;
                        pause_r <= 1'b1;
                    end else begin
                        w_addr_r <= w_addr_r + W_ONE;
                        if (w_addr_r == LEAD_LAST) begin
                            state_r  <= STREAM;
                            en_rd_r  <= 1'b1;
                            r_addr_r <= R_ZERO;
                            phase_r  <= 2'd0;
                        end else begin
                            state_r  <= FILL;
                        end
                    end
                end

                STREAM: begin
                    if (!run_s) begin
                        state_r <= HOLD;
                        saved_r <= STREAM;
                        en_wr_r <= 1'b0;
                        wea_r   <= 1'b0;
                        en_rd_r <= 1'b0;
                        pause_r <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 2'd1;
                        sel_r   <= sel_r + 3'd1;
                        if (read_step_s) begin
                            r_addr_r <= r_addr_r + R_ONE;
                            count_r  <= count_r + R_ONE;
                        end else begin
                            r_addr_r <= r_addr_r;
                        end
                        // Guarded cycles stall the writer only; reads keep going.
                        if (guard_s) begin
                            pause_r <= 1'b1;
                            wea_r   <= 1'b0;
                        end else if (w_addr_r == W_LAST) begin
                            pause_r  <= 1'b0;
                            w_addr_r <= W_ZERO;
                            en_wr_r  <= 1'b0;
                            wea_r    <= 1'b0;
                            state_r  <= DRAIN;
                        end else begin
                            pause_r  <= 1'b0;
                            wea_r    <= 1'b1;
                            w_addr_r <= w_addr_r + W_ONE;
                        end
                    end
                end

                DRAIN: begin
                    // Final read edge wins over a simultaneous stop request.
                    if (read_step_s && (count_r == CNT_LAST)) begin
                        phase_r    <= phase_r + 2'd1;
                        sel_r      <= sel_r + 3'd1;
                        r_addr_r   <= r_addr_r + R_ONE;
                        count_r    <= count_r + R_ONE;
                        en_rd_r    <= 1'b0;
                        pause_r    <= 1'b0;
                        complete_r <= 1'b1;
                        state_r    <= DONE;
                    end else if (!run_s) begin
                        state_r <= HOLD;
                        saved_r <= DRAIN;
                        en_rd_r <= 1'b0;
                        pause_r <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 2'd1;
                        sel_r   <= sel_r + 3'd1;
                        if (read_step_s) begin
                            r_addr_r <= r_addr_r + R_ONE;
                            count_r  <= count_r + R_ONE;
                        end else begin
                            r_addr_r <= r_addr_r;
                        end
                    end
                end

                HOLD: begin
                    if (run_s) begin
                        state_r <= saved_r;
                        pause_r <= 1'b0;
                        case (saved_r)
                            FILL: begin
                                en_wr_r <= 1'b1;
                                wea_r   <= 1'b1;
                                en_rd_r <= 1'b0;
                            end
                            STREAM: begin
                                en_wr_r <= 1'b1;
                                wea_r   <= 1'b1;
                                en_rd_r <= 1'b1;
                            end
                            DRAIN: begin
                                en_wr_r <= 1'b0;
                                wea_r   <= 1'b0;
                                en_rd_r <= 1'b1;
                            end
                            default: begin
                                state_r <= IDLE;
                                en_wr_r <= 1'b0;
                                wea_r   <= 1'b0;
                                en_rd_r <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_r <= HOLD;
                    end
                end

                DONE: begin
                    if (!run_s) begin
                        state_r    <= IDLE;
                        saved_r    <= IDLE;
                        w_addr_r   <= W_ZERO;
                        r_addr_r   <= R_ZERO;
                        count_r    <= R_ZERO;
                        phase_r    <= 2'd0;
                        sel_r      <= 3'd0;
                        complete_r <= 1'b0;
                        pause_r    <= 1'b0;
                    end else begin
                        state_r    <= DONE;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    saved_r    <= IDLE;
                    w_addr_r   <= W_ZERO;
                    r_addr_r   <= R_ZERO;
                    count_r    <= R_ZERO;
                    phase_r    <= 2'd0;
                    sel_r      <= 3'd0;
                    en_wr_r    <= 1'b0;
                    wea_r      <= 1'b0;
                    en_rd_r    <= 1'b0;
                    pause_r    <= 1'b0;
                    complete_r <= 1'b0;
                end
            endcase
        end
    end

    assign en_wr       = en_wr_r;
    assign wea         = wea_r;
    assign W_BRAM_ADDR = w_addr_r;
    assign en_rd       = en_rd_r;
    assign R_BRAM_ADDR = r_addr_r;
    assign sel         = sel_r;
    assign count       = count_r;
    assign pause       = pause_r;
    assign complete    = complete_r;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for line_buffer_ctrl.
module tb_line_buffer_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  start;
    logic        en_wr;
    logic        wea;
    logic [10:0] W_BRAM_ADDR;
    logic        en_rd;
    logic [8:0]  R_BRAM_ADDR;
    logic [2:0]  sel;
    logic [8:0]  count;
    logic        pause;
    logic        complete;

    int checks   = 0;
    int failures = 0;

    // {en_wr, wea, en_rd, pause, complete, sel, count, R, W}
    logic [36:0] obs;
    assign obs = {en_wr, wea, en_rd, pause, complete, sel, count, R_BRAM_ADDR, W_BRAM_ADDR};
    localparam logic [36:0] NO_SEL = ~(37'h7 << 29);

    logic [36:0] exp_q[$];

    line_buffer_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .en_wr       (en_wr),
        .wea         (wea),
        .W_BRAM_ADDR (W_BRAM_ADDR),
        .en_rd       (en_rd),
        .R_BRAM_ADDR (R_BRAM_ADDR),
        .sel         (sel),
        .count       (count),
        .pause       (pause),
        .complete    (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] exp_vec(input logic ewr, input logic we, input logic erd,
                                            input logic pa, input logic cp, input logic [2:0] s,
                                            input logic [8:0] c, input logic [8:0] r,
                                            input logic [10:0] w);
        return {ewr, we, erd, pa, cp, s, c, r, w};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 3'd0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        logic [36:0] e;
        reset = 1'b1;
        start = 3'd0;
        #2 reset = 1'b0;
        #1;
        e = 37'd0;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", obs, e);
        end
        tick(2);
        reset = 1'b1;
        tick(3);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL idle_hold: got %h expected %h", obs, e);
        end
    endtask

    // FILL then STREAM start-up sequence from reset with a given nonzero start.
    task automatic test_startup(input logic [2:0] sv, input string name);
        logic [36:0] e;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 32; k++)
            exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 9'd0, 11'(k)));
        for (int k = 0; k <= 12; k++)
            exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k % 8), 9'(k / 4),
                                    9'(k / 4), 11'(32 + k)));
        start = sv;
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", name, obs, e);
            end
        end
        start = 3'd0;
    endtask

    task automatic test_full_frame();
        logic [10:0] wq[$];
        logic [8:0]  rq[$];
        logic [8:0]  prev_r;
        logic        prev_last;
        int          wr_pulses;
        int          rd_incs;
        logic [36:0] e;
        do_reset();
        for (int i = 0; i < 2048; i++) wq.push_back(11'(i));
        for (int i = 1; i <= 512; i++) rq.push_back(9'(i % 512));
        prev_r = 9'd0;
        prev_last = 1'b0;
        wr_pulses = 0;
        rd_incs = 0;
        start = 3'd1;
        for (int cyc = 0; cyc < 6000 && complete !== 1'b1; cyc++) begin
            tick(1);
            if (prev_last) begin
                checks++;
                if ({en_wr, wea, en_rd, W_BRAM_ADDR} !== {1'b0, 1'b0, 1'b1, 11'd0}) begin
                    failures++;
                    $display("FAIL drain_entry: got en_wr=%b wea=%b en_rd=%b W=%0d expected 0 0 1 0",
                             en_wr, wea, en_rd, W_BRAM_ADDR);
                end
            end
            prev_last = wea && (W_BRAM_ADDR == 11'd2047);
            if (wea) begin
                wr_pulses++;
                checks++;
                if (wq.size() == 0 || W_BRAM_ADDR !== wq[0]) begin
                    failures++;
                    $display("FAIL write_addr: got %0d expected %0d (left %0d)", W_BRAM_ADDR,
                             (wq.size() > 0) ? wq[0] : 11'd0, wq.size());
                end
                if (wq.size() > 0) void'(wq.pop_front());
            end
            if (R_BRAM_ADDR !== prev_r) begin
                rd_incs++;
                checks++;
                if (rq.size() == 0 || R_BRAM_ADDR !== rq[0]) begin
                    failures++;
                    $display("FAIL read_addr: got %0d expected %0d (left %0d)", R_BRAM_ADDR,
                             (rq.size() > 0) ? rq[0] : 9'd0, rq.size());
                end
                if (rq.size() > 0) void'(rq.pop_front());
            end
            prev_r = R_BRAM_ADDR;
        end
        checks++;
        if (complete !== 1'b1) begin
            failures++;
            $display("FAIL frame_timeout: got complete=%b expected 1", complete);
        end
        checks++;
        if (wr_pulses != 2048) begin
            failures++;
            $display("FAIL write_pulses: got %0d expected 2048", wr_pulses);
        end
        checks++;
        if (rd_incs != 512) begin
            failures++;
            $display("FAIL read_increments: got %0d expected 512", rd_incs);
        end
        e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 9'd0, 9'd0, 11'd0);
        tick(3);
        checks++;
        if ((obs & NO_SEL) !== (e & NO_SEL)) begin
            failures++;
            $display("FAIL done_hold: got %h expected %h", obs & NO_SEL, e & NO_SEL);
        end
        start = 3'd0;
        tick(1);
        checks++;
        if (obs !== 37'd0) begin
            failures++;
            $display("FAIL done_to_idle: got %h expected %h", obs, 37'd0);
        end
    endtask

    // Stop request coinciding with the last read edge still lands in DONE.
    task automatic test_done_priority();
        logic [36:0] e;
        int n;
        do_reset();
        start = 3'd1;
        n = 0;
        while (R_BRAM_ADDR !== 9'd511 && n < 3000) begin
            tick(1);
            n++;
        end
        checks++;
        if (R_BRAM_ADDR !== 9'd511) begin
            failures++;
            $display("FAIL prio_wait: got R=%0d expected 511", R_BRAM_ADDR);
        end
        tick(3);
        start = 3'd0;
        tick(1);
        e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 9'd0, 9'd0, 11'd0);
        checks++;
        if ((obs & NO_SEL) !== (e & NO_SEL)) begin
            failures++;
            $display("FAIL done_priority: got %h expected %h", obs & NO_SEL, e & NO_SEL);
        end
        tick(1);
        checks++;
        if (obs !== 37'd0) begin
            failures++;
            $display("FAIL prio_idle: got %h expected %h", obs, 37'd0);
        end
    endtask

    task automatic test_hold();
        logic [36:0] e;
        int n;
        do_reset();
        start = 3'd1;
        n = 0;
        while (W_BRAM_ADDR !== 11'd100 && n < 500) begin
            tick(1);
            n++;
        end
        // W=100 is stream step 68: sel=4, R=count=17.
        e = exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 9'd17, 9'd17, 11'd100);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL hold_reach: got %h expected %h", obs, e);
        end
        start = 3'd0;
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4,
                                                            9'd17, 9'd17, 11'd100));
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL hold_frozen: got %h expected %h", obs, e);
            end
        end
        start = 3'd1;
        exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 9'd17, 9'd17, 11'd100));
        for (int j = 1; j <= 5; j++)
            exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'((4 + j) % 8),
                                    9'((68 + j) / 4), 9'((68 + j) / 4), 11'(100 + j)));
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL hold_resume: got %h expected %h", obs, e);
            end
        end
        start = 3'd0;
    endtask

    task automatic test_overrun();
        logic [36:0] e;
        int n;
        do_reset();
        start = 3'd1;
        n = 0;
        while (R_BRAM_ADDR !== 9'd2 && n < 200) begin
            tick(1);
            n++;
        end
        e = exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 9'd2, 9'd2, 11'd40);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL overrun_reach: got %h expected %h", obs, e);
        end
        // W - 4*R = 4 - 8 = 2044 (mod 2048)
        force dut.w_addr_r = 11'd4;
        for (int j = 1; j <= 3; j++)
            exp_q.push_back(exp_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'(j), 9'd2, 9'd2, 11'd4));
        exp_q.push_back(exp_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 9'd3, 9'd3, 11'd4));
        exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 9'd3, 9'd3, 11'd5));
        tick(1);
        release dut.w_addr_r;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL overrun_guard: got %h expected %h", obs, e);
        end
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL overrun_guard: got %h expected %h", obs, e);
            end
        end
        start = 3'd0;
    endtask

    task automatic test_reset_mid_stream();
        logic [36:0] e;
        do_reset();
        start = 3'd1;
        tick(50);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 37'd0) begin
            failures++;
            $display("FAIL reset_mid_stream: got %h expected %h", obs, 37'd0);
        end
        tick(1);
        reset = 1'b1;
        exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 9'd0, 11'd0));
        exp_q.push_back(exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 9'd0, 11'd1));
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_restart: got %h expected %h", obs, e);
            end
        end
        start = 3'd0;
    endtask

    initial begin
        reset = 1'b1;
        start = 3'd0;
        test_reset();
        test_startup(3'b001, "startup_001");
        test_startup(3'b100, "startup_100");
        test_hold();
        test_overrun();
        test_reset_mid_stream();
        test_full_frame();
        test_done_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
